// File: rtl/gshare_predictor_pkg.sv
// Shared types and helpers for the gshare branch direction predictor:
// RV32I opcodes, predictor states, history folding and counter arithmetic.
package gshare_predictor_pkg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } bp_state_e;

    // Weakly-not-taken counter value, 2**(ctr_w-1)-1.
    function automatic logic [31:0] wnt_value(input int ctr_w);
        return (32'd1 << (ctr_w - 1)) - 32'd1;
    endfunction

    // XOR-fold a history of hist_len bits into idx_w bits. Bit i of the
    // history lands in bit (i mod idx_w), which is the same as XORing the
    // LSB-aligned idx_w-bit chunks with the top chunk zero-padded.
    function automatic logic [31:0] fold_hist(input logic [63:0] h,
                                              input int hist_len,
                                              input int idx_w);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 64; i++) begin
            if (i < hist_len) begin
                r[5'(i % idx_w)] = r[5'(i % idx_w)] ^ h[6'(i)];
            end
        end
        return r;
    endfunction

    // Saturating up/down counter step for a ctr_w-bit unsigned counter.
    function automatic logic [31:0] ctr_update(input logic [31:0] ctr,
                                               input logic taken,
                                               input int ctr_w);
        logic [31:0] max_v;
        logic [31:0] r;
        max_v = (32'd1 << ctr_w) - 32'd1;
        if (taken) begin
            r = (ctr >= max_v) ? max_v : ctr + 32'd1;
        end else begin
            r = (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gshare_predictor_pht.sv
// Pattern history table: 2**IDX_W saturating counters with one combinational
// read port and one synchronous write port. The write port either stores the
// initial value at the sweep pointer or applies a trained counter step.
module gshare_predictor_pht
    import gshare_predictor_pkg::*;
#(
    parameter int IDX_W = 8,
    parameter int CTR_W = 2,
    parameter logic [CTR_W-1:0] WNT = '0
) (
    input  logic             clk,
    input  logic             sweep_we,
    input  logic [IDX_W-1:0] sweep_idx,
    input  logic             train_we,
    input  logic [IDX_W-1:0] train_idx,
    input  logic             train_taken,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_ctr
);

    localparam int DEPTH = 1 << IDX_W;

    // Contents are intentionally not reset: the post-reset sweep defines them.
    logic [CTR_W-1:0] mem_r [DEPTH];
    logic [31:0]      wr_ctr_full_s;
    logic             unused_s;

    assign wr_ctr_full_s = ctr_update(32'(mem_r[train_idx]), train_taken, CTR_W);
    assign rd_ctr        = mem_r[rd_idx];
    assign unused_s      = ^wr_ctr_full_s;

    // Single write port: sweep initialisation has priority over training.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem_r[sweep_idx] <= WNT;
        end else if (train_we) begin
            mem_r[train_idx] <= wr_ctr_full_s[CTR_W-1:0];
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare global-history branch direction predictor. Fetch lookups return a
// registered prediction plus the history snapshot; execute returns that
// snapshot with the outcome to train the table and advance the history.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int HIST_LEN = 8,
    parameter int IDX_W    = 8,
    parameter int CTR_W    = 2,
    parameter int PC_LSB   = 2,
    parameter int BYPASS   = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                fetch_valid,
    input  logic [31:0]         fetch_pc,
    output logic                pred_valid,
    output logic                pred_taken,
    output logic [HIST_LEN-1:0] pred_hist,
    output logic                ready,
    input  logic                res_valid,
    input  rv32i_opcode         res_opcode,
    input  logic [31:0]         res_pc,
    input  logic [HIST_LEN-1:0] res_hist,
    input  logic                res_taken
);

    localparam logic [CTR_W-1:0] WNT      = CTR_W'(wnt_value(CTR_W));
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

    bp_state_e           state_r;
    logic [IDX_W-1:0]    ptr_r;
    logic [HIST_LEN-1:0] ghr_r;
    logic                pred_valid_r;
    logic                pred_taken_r;
    logic [HIST_LEN-1:0] pred_hist_r;

    logic                is_ready_s;
    logic                train_br_s;
    logic                train_jmp_s;
    logic [31:0]         fetch_fold_s;
    logic [31:0]         res_fold_s;
    logic [IDX_W-1:0]    fetch_idx_s;
    logic [IDX_W-1:0]    res_idx_s;
    logic [CTR_W-1:0]    rd_ctr_s;
    logic [31:0]         bypass_ctr_full_s;
    logic [CTR_W-1:0]    lookup_ctr_s;
    logic                shift_in_s;
    logic [HIST_LEN:0]   ghr_ext_s;
    logic [HIST_LEN-1:0] ghr_shifted_s;
    logic                unused_s;

    assign is_ready_s  = (state_r == ST_READY);
    assign train_br_s  = is_ready_s && res_valid && (res_opcode == op_br);
    assign train_jmp_s = is_ready_s && res_valid &&
                         ((res_opcode == op_jal) || (res_opcode == op_jalr));

    assign fetch_fold_s = fold_hist(64'(ghr_r), HIST_LEN, IDX_W);
    assign res_fold_s   = fold_hist(64'(res_hist), HIST_LEN, IDX_W);
    assign fetch_idx_s  = fetch_pc[PC_LSB +: IDX_W] ^ fetch_fold_s[IDX_W-1:0];
    assign res_idx_s    = res_pc[PC_LSB +: IDX_W] ^ res_fold_s[IDX_W-1:0];

    // The counter a same-cycle branch write would store at the lookup index;
    // only meaningful when the two indices match.
    assign bypass_ctr_full_s = ctr_update(32'(rd_ctr_s), res_taken, CTR_W);

    assign ghr_ext_s     = {ghr_r, shift_in_s};
    assign ghr_shifted_s = ghr_ext_s[HIST_LEN-1:0];

    assign ready      = is_ready_s;
    assign pred_valid = pred_valid_r;
    assign pred_taken = pred_taken_r;
    assign pred_hist  = pred_hist_r;

    assign unused_s = ^{fetch_pc, res_pc, fetch_fold_s, res_fold_s,
                        bypass_ctr_full_s, ghr_ext_s};

    gshare_predictor_pht #(
        .IDX_W (IDX_W),
        .CTR_W (CTR_W),
        .WNT   (WNT)
    ) u_pht (
        .clk         (clk),
        .sweep_we    (state_r == ST_INIT),
        .sweep_idx   (ptr_r),
        .train_we    (train_br_s),
        .train_idx   (res_idx_s),
        .train_taken (res_taken),
        .rd_idx      (fetch_idx_s),
        .rd_ctr      (rd_ctr_s)
    );

    // Select the counter seen by the lookup, forwarding a colliding write if enabled.
    always_comb begin
        lookup_ctr_s = rd_ctr_s;
        if ((BYPASS != 0) && train_br_s && (res_idx_s == fetch_idx_s)) begin
            lookup_ctr_s = bypass_ctr_full_s[CTR_W-1:0];
        end else begin
            lookup_ctr_s = rd_ctr_s;
        end
    end

    // Bit shifted into the history: branch outcome, or 1 for jumps.
    always_comb begin
        shift_in_s = 1'b1;
        if (train_br_s) begin
            shift_in_s = res_taken;
        end else begin
            shift_in_s = 1'b1;
        end
    end

    // Control state: initialisation sweep, then history updates while ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_INIT;
            ptr_r   <= '0;
            ghr_r   <= '0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    ptr_r <= ptr_r + IDX_W'(1);
                    if (ptr_r == LAST_IDX) begin
                        state_r <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (train_br_s || train_jmp_s) begin
                        ghr_r <= ghr_shifted_s;
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                    ptr_r   <= '0;
                end
            endcase
        end
    end

    // Registered prediction outputs; taken/hist hold when no lookup is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pred_valid_r <= 1'b0;
            pred_taken_r <= 1'b0;
            pred_hist_r  <= '0;
        end else if (is_ready_s && fetch_valid) begin
            pred_valid_r <= 1'b1;
            pred_taken_r <= lookup_ctr_s[CTR_W-1];
            pred_hist_r  <= ghr_r;
        end else begin
            pred_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: two instances (12-bit history / 256 entries /
// 2-bit counters without bypass, and 3-bit history / 32 entries / 3-bit
// counters with bypass) driven in lockstep and compared every cycle against
// an arithmetic reference model, plus directed checks with fixed values.
module tb_gshare_predictor;
    import gshare_predictor_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        res_valid;
    rv32i_opcode res_opcode;
    logic [31:0] res_pc;
    logic [11:0] res_hist;
    logic        res_taken;

    logic        rdy0, pv0, pt0;
    logic [11:0] ph0;
    logic        rdy1, pv1, pt1;
    logic [2:0]  ph1;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state, one slot per instance
    int m_cnt [2];
    int m_ghr [2];
    int m_pt  [2];
    int m_ph  [2];
    int m_pv  [2];
    int m_rdy [2];
    int m_pht [2][256];

    gshare_predictor #(.HIST_LEN(12), .IDX_W(8), .CTR_W(2), .PC_LSB(2), .BYPASS(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_valid(pv0), .pred_taken(pt0), .pred_hist(ph0), .ready(rdy0),
        .res_valid(res_valid), .res_opcode(res_opcode), .res_pc(res_pc),
        .res_hist(res_hist), .res_taken(res_taken));

    gshare_predictor #(.HIST_LEN(3), .IDX_W(5), .CTR_W(3), .PC_LSB(2), .BYPASS(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_valid(pv1), .pred_taken(pt1), .pred_hist(ph1), .ready(rdy1),
        .res_valid(res_valid), .res_opcode(res_opcode), .res_pc(res_pc),
        .res_hist(res_hist[2:0]), .res_taken(res_taken));

    always #5 clk = ~clk;

    function automatic int hl(int k); return (k == 0) ? 12 : 3; endfunction
    function automatic int iw(int k); return (k == 0) ? 8 : 5;  endfunction
    function automatic int cw(int k); return (k == 0) ? 2 : 3;  endfunction
    function automatic int bp(int k); return (k == 0) ? 0 : 1;  endfunction

    // fold: XOR of iw-bit chunks of the history, taken from the LSB upwards
    function automatic int fold_m(int k, int h);
        int r = 0;
        while (h != 0) begin
            r = r ^ (h % (1 << iw(k)));
            h = h / (1 << iw(k));
        end
        return r;
    endfunction

    function automatic int idx_m(int k, int pc, int h);
        return ((pc / 4) % (1 << iw(k))) ^ fold_m(k, h);
    endfunction

    function automatic int upd_m(int k, int c, int t);
        if (t != 0) return (c + 1 > (1 << cw(k)) - 1) ? (1 << cw(k)) - 1 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    task automatic mreset(int k);
        m_cnt[k] = 0; m_ghr[k] = 0; m_pt[k] = 0; m_ph[k] = 0; m_pv[k] = 0; m_rdy[k] = 0;
    endtask

    task automatic mstep(int k);
        int hm, rh, ri, fi, c, is_br, is_j;
        hm = (1 << hl(k)) - 1;
        if (m_rdy[k] == 0) begin
            m_pv[k] = 0;
            m_cnt[k]++;
            if (m_cnt[k] == (1 << iw(k))) begin
                m_rdy[k] = 1;
                for (int i = 0; i < 256; i++) m_pht[k][i] = (1 << (cw(k) - 1)) - 1;
            end
        end else begin
            rh    = 32'(res_hist) & hm;
            ri    = idx_m(k, fetch_pc === 32'hx ? 0 : int'(res_pc), rh);
            is_br = (res_valid && res_opcode == op_br) ? 1 : 0;
            is_j  = (res_valid && (res_opcode == op_jal || res_opcode == op_jalr)) ? 1 : 0;
            if (fetch_valid) begin
                fi = idx_m(k, int'(fetch_pc), m_ghr[k]);
                c  = m_pht[k][fi];
                if (bp(k) != 0 && is_br != 0 && ri == fi) c = upd_m(k, c, int'(res_taken));
                m_pt[k] = c / (1 << (cw(k) - 1));
                m_ph[k] = m_ghr[k];
                m_pv[k] = 1;
            end else begin
                m_pv[k] = 0;
            end
            if (is_br != 0) begin
                m_pht[k][ri] = upd_m(k, m_pht[k][ri], int'(res_taken));
                m_ghr[k] = (m_ghr[k] * 2 + int'(res_taken)) & hm;
            end else if (is_j != 0) begin
                m_ghr[k] = (m_ghr[k] * 2 + 1) & hm;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ready0", 32'(rdy0), m_rdy[0]);
        chk("pred_valid0", 32'(pv0), m_pv[0]);
        chk("pred_taken0", 32'(pt0), m_pt[0]);
        chk("pred_hist0", 32'(ph0), m_ph[0]);
        chk("ready1", 32'(rdy1), m_rdy[1]);
        chk("pred_valid1", 32'(pv1), m_pv[1]);
        chk("pred_taken1", 32'(pt1), m_pt[1]);
        chk("pred_hist1", 32'(ph1), m_ph[1]);
    endtask

    // advance model and DUTs by one rising edge, then compare
    task automatic step();
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) mreset(k);
            else mstep(k);
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        fetch_valid = 1'b0; fetch_pc = 32'h0;
        res_valid = 1'b0; res_opcode = op_imm; res_pc = 32'h0; res_hist = 12'h0; res_taken = 1'b0;
    endtask

    task automatic train(input rv32i_opcode op, input logic [31:0] pc,
                         input logic [11:0] h, input logic t);
        res_valid = 1'b1; res_opcode = op; res_pc = pc; res_hist = h; res_taken = t;
        step();
        idle();
    endtask

    task automatic lookup(input logic [31:0] pc);
        fetch_valid = 1'b1; fetch_pc = pc;
        step();
        idle();
    endtask

    task automatic async_reset();
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) mreset(k);
        check_all();
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;

        // reset/sweep with fetch held active at 0x100
        fetch_valid = 1'b1; fetch_pc = 32'h100;
        for (int i = 1; i <= 256; i++) begin
            step();
            chk("sweep_ready0", 32'(rdy0), (i == 256) ? 32'd1 : 32'd0);
            chk("sweep_pv0", 32'(pv0), 32'd0);
        end
        step();
        chk("first_pv", 32'(pv0), 32'd1);
        chk("first_taken", 32'(pt0), 32'd0);
        idle();

        // training saturation at idx 0x10
        repeat (2) train(op_br, 32'h40, 12'h0, 1'b1);
        lookup(32'h4C);
        chk("sat_taken", 32'(pt0), 32'd1);
        repeat (3) train(op_br, 32'h40, 12'h0, 1'b1);
        repeat (2) train(op_br, 32'h40, 12'h0, 1'b0);
        lookup(32'h1B0);
        chk("sat_back", 32'(pt0), 32'd0);

        // history folding: GHR all ones selects idx 0xF0 for PC 0
        repeat (2) train(op_br, 32'h3C0, 12'h0, 1'b1);
        repeat (12) train(op_br, 32'h800, 12'h0, 1'b1);
        lookup(32'h0);
        chk("fold_hist", 32'(ph0), 32'hFFF);
        chk("fold_taken", 32'(pt0), 32'd1);

        // jumps shift a 1 only; other opcodes do nothing
        train(op_br, 32'h800, 12'h0, 1'b0);
        repeat (2) train(op_jal, 32'h100, 12'h0, 1'b1);
        lookup(32'h2D0);
        chk("jal_hist", 32'(ph0), 32'hFFB);
        chk("jal_pht", 32'(pt0), 32'd0);
        repeat (2) train(op_load, 32'h100, 12'h0, 1'b1);
        lookup(32'h2D0);
        chk("load_hist", 32'(ph0), 32'hFFB);
        chk("load_pht", 32'(pt0), 32'd0);

        // mid-operation reset, then reset again at sweep edge 100
        async_reset();
        step();
        reset_n = 1'b1;
        repeat (100) step();
        async_reset();
        repeat (2) step();
        reset_n = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            step();
            chk("resweep_ready0", 32'(rdy0), (i == 256) ? 32'd1 : 32'd0);
        end

        // same-cycle collision at idx 0, counters at their initial value
        fetch_valid = 1'b1; fetch_pc = 32'h0;
        train(op_br, 32'h0, 12'h0, 1'b1);
        chk("coll_nobypass", 32'(pt0), 32'd0);
        chk("coll_bypass", 32'(pt1), 32'd1);
        chk("coll_hist0", 32'(ph0), 32'd0);
        chk("coll_hist1", 32'(ph1), 32'd0);
        lookup(32'h0);
        chk("post_coll_hist", 32'(ph0), 32'd1);

        // randomized traffic over a small PC range to force collisions
        for (int n = 0; n < 1500; n++) begin
            fetch_valid = 1'($urandom_range(0, 1));
            fetch_pc    = 32'($urandom_range(0, 63)) << 2;
            res_valid   = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0: res_opcode = op_jal;
                1: res_opcode = op_jalr;
                2: res_opcode = op_load;
                3: res_opcode = op_store;
                default: res_opcode = op_br;
            endcase
            res_pc    = 32'($urandom_range(0, 63)) << 2;
            res_hist  = ($urandom_range(0, 1) != 0) ? 12'(m_ghr[0]) : 12'($urandom_range(0, 4095));
            res_taken = 1'($urandom_range(0, 1));
            step();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
